// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use stall controller for the EX operand muxes.
// Optional FWD_ZERO_GUARD_EN: register 0 is hardwired zero and never forwards.
module fwd_hazard_ctrl #(
  parameter int REG_W    = 6,
  parameter int LOAD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             ex_bubble
);

`ifdef FWD_ZERO_GUARD_EN
  localparam bit ZERO_GUARD = 1'b1;
`else
  localparam bit ZERO_GUARD = 1'b0;
`endif

  localparam logic [1:0] LAT_M1 = 2'(LOAD_LAT - 1);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic             uses_rs;
    logic             uses_rt;
    logic             regwrite;
    logic             memread;
  } ex_rec_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memread;
  } mem_rec_t;

  // WB only needs to know whether it writes rd; load data is ready there.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             regwrite;
  } wb_rec_t;

  typedef enum logic {
    IDLE,
    STALL
  } state_t;

  ex_rec_t  ex_q;
  mem_rec_t mem_q;
  wb_rec_t  wb_q;
  state_t   state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic     hz;

  function automatic logic rd_live(input logic [REG_W-1:0] r);
    return !ZERO_GUARD || (r != '0);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      mem_q <= '{ex_q.valid, ex_q.rd,
                 ex_q.regwrite, ex_q.memread};
      wb_q  <= '{mem_q.valid, mem_q.rd,
                 mem_q.regwrite};
      if (flush || stall)
        ex_q <= '0;
      else
        ex_q <= '{id_valid, id_rs, id_rt, id_rd,
                  id_uses_rs, id_uses_rt,
                  id_regwrite, id_memread};
    end
  end

  assign hz = id_valid & ex_q.valid
            & ex_q.memread & ex_q.regwrite
            & rd_live(ex_q.rd)
            & ((id_uses_rs & (id_rs == ex_q.rd))
             | (id_uses_rt & (id_rt == ex_q.rd)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE:  cnt_d = (hz && !flush) ? LAT_M1 : 2'd0;
      STALL: cnt_d = flush ? 2'd0 : cnt_q - 2'd1;
      default: cnt_d = 2'd0;
    endcase
    state_d = (cnt_d != 2'd0) ? STALL : IDLE;
  end

  assign stall = (hz | (cnt_q != 2'd0)) & ~flush;

  logic mem_ok, wb_ok;
  logic a_mem, a_wb, b_mem, b_wb;

  assign mem_ok = mem_q.valid & mem_q.regwrite
                & ~mem_q.memread & rd_live(mem_q.rd);
  assign wb_ok  = wb_q.valid & wb_q.regwrite
                & rd_live(wb_q.rd);

  assign a_mem = ex_q.valid & ex_q.uses_rs & mem_ok
               & (mem_q.rd == ex_q.rs);
  assign a_wb  = ex_q.valid & ex_q.uses_rs & wb_ok
               & (wb_q.rd == ex_q.rs) & ~a_mem;
  assign b_mem = ex_q.valid & ex_q.uses_rt & mem_ok
               & (mem_q.rd == ex_q.rt);
  assign b_wb  = ex_q.valid & ex_q.uses_rt & wb_ok
               & (wb_q.rd == ex_q.rt) & ~b_mem;

  always_comb begin
    fwd_a_sel = 2'b00;
    unique case (1'b1)
      a_mem:   fwd_a_sel = 2'b01;
      a_wb:    fwd_a_sel = 2'b10;
      default: fwd_a_sel = 2'b00;
    endcase
  end

  always_comb begin
    fwd_b_sel = 2'b00;
    unique case (1'b1)
      b_mem:   fwd_b_sel = 2'b01;
      b_wb:    fwd_b_sel = 2'b10;
      default: fwd_b_sel = 2'b00;
    endcase
  end

  assign ex_bubble = ~ex_q.valid;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: LOAD_LAT=1 and LOAD_LAT=3 instances.
// Zero-register expectations follow FWD_ZERO_GUARD_EN.
module tb_fwd_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [5:0] id_rs, id_rt, id_rd;
  logic       id_uses_rs, id_uses_rt;
  logic       id_regwrite, id_memread;
  logic       flush;

  logic       stall1, bub1;
  logic [1:0] fa1, fb1;
  logic       stall3, bub3;
  logic [1:0] fa3, fb3;

  int checks = 0;
  int errors = 0;

`ifdef FWD_ZERO_GUARD_EN
  localparam bit ZG = 1'b1;
`else
  localparam bit ZG = 1'b0;
`endif

  fwd_hazard_ctrl #(.REG_W(6), .LOAD_LAT(1)) u1 (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs),
    .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .flush(flush), .stall(stall1),
    .fwd_a_sel(fa1), .fwd_b_sel(fb1),
    .ex_bubble(bub1)
  );

  fwd_hazard_ctrl #(.REG_W(6), .LOAD_LAT(3)) u3 (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs),
    .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .flush(flush), .stall(stall3),
    .fwd_a_sel(fa3), .fwd_b_sel(fb3),
    .ex_bubble(bub3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [1:0] obs,
                     input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b",
             tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_uses_rs = 0; id_uses_rt = 0;
    id_regwrite = 0; id_memread = 0;
  endtask

  // valid instruction: rs, rt, rd, uses_rs, uses_rt, regwrite, memread
  task automatic issue(input int rs, input int rt,
                       input int rd, input bit urs,
                       input bit urt, input bit rw,
                       input bit mr);
    id_valid = 1;
    id_rs = 6'(rs); id_rt = 6'(rt); id_rd = 6'(rd);
    id_uses_rs = urs; id_uses_rt = urt;
    id_regwrite = rw; id_memread = mr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; flush = 0;
    idle();
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    rst = 1; flush = 0;
    idle();
    #12 rst = 0;

    // async reset mid-cycle
    issue(1, 2, 5, 1, 1, 1, 0);
    tick();
    idle();
    #1;
    chk("pre_rst_bubble", 2'(bub1), 2'b00);
    #2 rst = 1;
    #1;
    chk("rst_stall", 2'(stall1), 2'b00);
    chk("rst_fa", fa1, 2'b00);
    chk("rst_fb", fb1, 2'b00);
    chk("rst_bubble", 2'(bub1), 2'b01);
    chk("rst_bubble3", 2'(bub3), 2'b01);

    // back-to-back ALU pair
    do_reset();
    tick();
    issue(1, 2, 5, 1, 1, 1, 0);
    tick();
    issue(5, 5, 6, 1, 1, 1, 0);
    tick();
    idle();
    #1;
    chk("b2b_fa", fa1, 2'b01);
    chk("b2b_fb", fb1, 2'b01);
    chk("b2b_bubble", 2'(bub1), 2'b00);
    chk("b2b_stall", 2'(stall1), 2'b00);
    tick();
    chk("b2b_after_fa", fa1, 2'b00);
    chk("b2b_after_bub", 2'(bub1), 2'b01);

    // distance-2 dependency
    do_reset();
    tick();
    issue(1, 2, 5, 1, 1, 1, 0);
    tick();
    issue(3, 4, 9, 1, 1, 1, 0);
    tick();
    issue(5, 4, 6, 1, 1, 1, 0);
    tick();
    idle();
    #1;
    chk("d2_fa", fa1, 2'b10);
    chk("d2_fb", fb1, 2'b00);

    // r5 in both MEM and WB: newest wins
    do_reset();
    tick();
    issue(1, 2, 5, 1, 1, 1, 0);
    tick();
    issue(3, 4, 5, 1, 1, 1, 0);
    tick();
    issue(5, 1, 6, 1, 1, 1, 0);
    tick();
    idle();
    #1;
    chk("prio_fa", fa1, 2'b01);
    chk("prio_fb", fb1, 2'b00);

    // unused source register does not forward
    do_reset();
    tick();
    issue(1, 2, 5, 1, 1, 1, 0);
    tick();
    issue(5, 5, 6, 0, 0, 1, 0);
    tick();
    idle();
    #1;
    chk("nouse_fa", fa1, 2'b00);
    chk("nouse_fb", fb1, 2'b00);

    // load-use, LOAD_LAT=1
    do_reset();
    tick();
    issue(1, 0, 7, 1, 0, 1, 1);
    tick();
    issue(7, 3, 8, 1, 1, 1, 0);
    #1;
    chk("lu1_stall", 2'(stall1), 2'b01);
    tick();
    chk("lu1_bubble", 2'(bub1), 2'b01);
    chk("lu1_stall_end", 2'(stall1), 2'b00);
    chk("lu1_mem_load_fa", fa1, 2'b00);
    tick();
    idle();
    #1;
    chk("lu1_fa", fa1, 2'b10);
    chk("lu1_fb", fb1, 2'b00);
    chk("lu1_add_in_ex", 2'(bub1), 2'b00);

    // load-use via rt
    do_reset();
    tick();
    issue(1, 0, 7, 1, 0, 1, 1);
    tick();
    issue(3, 7, 8, 1, 1, 1, 0);
    #1;
    chk("lu_rt_stall", 2'(stall1), 2'b01);

    // load-use, LOAD_LAT=3, full length
    do_reset();
    tick();
    issue(1, 0, 7, 1, 0, 1, 1);
    tick();
    issue(7, 3, 8, 1, 1, 1, 0);
    #1;
    chk("lu3_stall_c1", 2'(stall3), 2'b01);
    tick();
    chk("lu3_stall_c2", 2'(stall3), 2'b01);
    chk("lu3_bub_c2", 2'(bub3), 2'b01);
    tick();
    chk("lu3_stall_c3", 2'(stall3), 2'b01);
    tick();
    chk("lu3_stall_done", 2'(stall3), 2'b00);
    tick();
    idle();
    #1;
    chk("lu3_add_in_ex", 2'(bub3), 2'b00);
    chk("lu3_fa", fa3, 2'b00);

    // LOAD_LAT=3 with flush in second stall cycle
    do_reset();
    tick();
    issue(1, 0, 7, 1, 0, 1, 1);
    tick();
    issue(7, 3, 8, 1, 1, 1, 0);
    #1;
    chk("fl_stall_c1", 2'(stall3), 2'b01);
    tick();
    flush = 1;
    #1;
    chk("fl_stall_c2", 2'(stall3), 2'b00);
    tick();
    flush = 0;
    idle();
    #1;
    chk("fl_stall_after", 2'(stall3), 2'b00);
    chk("fl_bubble", 2'(bub3), 2'b01);
    tick();
    chk("fl_cnt_clear", 2'(stall3), 2'b00);

    // reset in the middle of a stall
    do_reset();
    tick();
    issue(1, 0, 7, 1, 0, 1, 1);
    tick();
    issue(7, 3, 8, 1, 1, 1, 0);
    tick();
    chk("mid_stall_pre", 2'(stall3), 2'b01);
    idle();
    #2 rst = 1;
    #1;
    chk("mid_stall_rst", 2'(stall3), 2'b00);
    chk("mid_stall_bub", 2'(bub3), 2'b01);

    // zero register forwarding
    do_reset();
    tick();
    issue(1, 2, 0, 1, 1, 1, 0);
    tick();
    issue(0, 3, 6, 1, 1, 1, 0);
    tick();
    idle();
    #1;
    chk("zero_fa", fa1, ZG ? 2'b00 : 2'b01);
    chk("zero_fb", fb1, 2'b00);

    // zero register load-use
    do_reset();
    tick();
    issue(1, 0, 0, 1, 0, 1, 1);
    tick();
    issue(0, 3, 8, 1, 1, 1, 0);
    #1;
    chk("zero_hz", 2'(stall1), ZG ? 2'b00 : 2'b01);
    idle();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
